adder_pipe_scheduler: RTL and testbench

Scheduler that shares one parity-protected pipelined adder chain between two requesters. It arbitrates operand words round-robin into the chain and tracks in-flight slots. It checks the per-layer parity alarms and replays all in-flight work when any alarm fires. It sits between the requester-side logic and the top-level adder cascade, driving its input vector and consuming its sum and alarm outputs.

---
 rtl/adder_pipe_scheduler.sv | 194 +++++++++++++++++++
 tb/tb_adder_pipe_scheduler.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_pipe_scheduler.sv
// -----------------------------------------------------------------------------
// adder_pipe_scheduler
//
// Shares one parity-protected pipelined adder chain between two requesters.
// Operands are granted round-robin and driven straight onto the chain input.
// Each issued {id, operand} is also kept in a replay FIFO until it retires.
// When any layer raises a parity alarm on a live slot, the whole in-flight
// window is squashed and the FIFO contents are reissued oldest-first.
// Results therefore always come back in grant order.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   req_valid  per-requester operand valid
//   req_data   operands, requester i at [i*WORD_WIDTH +: WORD_WIDTH]
//   req_ready  per-requester grant (transfer on valid & ready)
//   pipe_in    operand driven into the chain
//   pipe_out   sum returned by the chain
//   pipe_alarm per-layer parity alarm, high = mismatch
//   rsp_valid  one-cycle result pulse
//   rsp_id     requester owning the result
//   rsp_data   result word
//   fault      sticky unrecoverable-error flag
//   err_cnt    saturating alarm-event counter
//
// Build option: define ADDER_SCHED_ERR_CNT_EN to enable the err_cnt counter;
// without it err_cnt is tied to zero.
// -----------------------------------------------------------------------------
module adder_pipe_scheduler #(
  parameter int WORD_WIDTH = 4,
  parameter int LAYERS     = 1,
  parameter int MAX_RETRY  = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [1:0]              req_valid,
  input  logic [2*WORD_WIDTH-1:0] req_data,
  output logic [1:0]              req_ready,
  output logic [WORD_WIDTH-1:0]   pipe_in,
  input  logic [WORD_WIDTH-1:0]   pipe_out,
  input  logic [LAYERS-1:0]       pipe_alarm,
  output logic                    rsp_valid,
  output logic                    rsp_id,
  output logic [WORD_WIDTH-1:0]   rsp_data,
  output logic                    fault,
  output logic [7:0]              err_cnt
);

  localparam int PW = (LAYERS > 1) ? $clog2(LAYERS) : 1;
  localparam int CW = $clog2(LAYERS + 1);
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  // Storage is rounded up to a power of two so pointers index it exactly.
  localparam int FD = 1 << PW;

  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_REPLAY = 2'd1;
  localparam logic [1:0] ST_FAULT  = 2'd2;

  logic [1:0]            r_state;
  logic                  r_rrPtr;
  logic [RW-1:0]         r_retryCnt;
  logic [LAYERS-1:0]     r_slotValid;
  logic [LAYERS-1:0]     r_slotId;
  logic                  r_fifoId   [FD];
  logic [WORD_WIDTH-1:0] r_fifoData [FD];
  logic [PW-1:0]         r_head;
  logic [PW-1:0]         r_tail;
  logic [PW-1:0]         r_rdPtr;
  logic [CW-1:0]         r_count;
  logic [CW-1:0]         r_replayLeft;

  logic                  w_error;
  logic                  w_retire;
  logic [CW-1:0]         w_countAfterRetire;
  logic                  w_canAccept;
  logic                  w_grant;
  logic                  w_grantId;
  logic [WORD_WIDTH-1:0] w_grantData;
  logic                  w_replayIssue;
  logic                  w_issue;
  logic                  w_issueId;
  logic [WORD_WIDTH-1:0] w_issueData;

  function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] p);
    return (p == PW'(LAYERS - 1)) ? '0 : p + PW'(1);
  endfunction

  // Slot k sits in layer k, so its alarm bit lines up with its valid bit.
  // Retirement and grants are blocked while rst is high so nothing leaves
  // or enters during the reset cycle.
  assign w_error            = (r_state != ST_FAULT) && |(pipe_alarm & r_slotValid);
  assign w_retire           = !rst && r_slotValid[LAYERS-1] && !w_error;
  assign w_countAfterRetire = r_count - CW'(w_retire);
  assign w_canAccept        = !rst && (r_state == ST_RUN) && !w_error &&
                              (w_countAfterRetire < CW'(LAYERS));

  assign w_grantId   = req_valid[r_rrPtr] ? r_rrPtr : ~r_rrPtr;
  assign w_grant     = w_canAccept && (req_valid != 2'b00);
  assign w_grantData = w_grantId ? req_data[2*WORD_WIDTH-1 -: WORD_WIDTH]
                                 : req_data[WORD_WIDTH-1:0];
  assign req_ready   = w_grant ? (w_grantId ? 2'b10 : 2'b01) : 2'b00;

  assign w_replayIssue = !rst && (r_state == ST_REPLAY) && !w_error;
  assign w_issue       = w_grant || w_replayIssue;
  assign w_issueId     = w_replayIssue ? r_fifoId[r_rdPtr]   : w_grantId;
  assign w_issueData   = w_replayIssue ? r_fifoData[r_rdPtr] : w_grantData;

  assign pipe_in   = w_issue ? w_issueData : '0;
  assign rsp_valid = w_retire;
  assign rsp_id    = w_retire && r_slotId[LAYERS-1];
  assign rsp_data  = w_retire ? pipe_out : '0;
  assign fault     = (r_state == ST_FAULT);

  // FIFO payload needs no reset; occupancy is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (w_grant) begin
      r_fifoId[r_tail]   <= w_grantId;
      r_fifoData[r_tail] <= w_grantData;
    end
  end

  // Control: slot window, FIFO pointers, arbitration and replay sequencing.
  // An error restarts replay from the FIFO head whichever state it hits in.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_RUN;
      r_rrPtr      <= 1'b0;
      r_retryCnt   <= '0;
      r_slotValid  <= '0;
      r_slotId     <= '0;
      r_head       <= '0;
      r_tail       <= '0;
      r_rdPtr      <= '0;
      r_count      <= '0;
      r_replayLeft <= '0;
    end else begin
      for (int k = 1; k < LAYERS; k++) begin
        r_slotValid[k] <= r_slotValid[k-1] && !w_error;
        r_slotId[k]    <= r_slotId[k-1];
      end
      r_slotValid[0] <= w_issue;
      r_slotId[0]    <= w_issueId;

      if (w_grant) begin
        r_tail  <= nextPtr(r_tail);
        r_rrPtr <= ~w_grantId;
      end
      if (w_retire) begin
        r_head <= nextPtr(r_head);
      end
      r_count <= r_count + CW'(w_grant) - CW'(w_retire);

      if (w_error) begin
        if (r_retryCnt == RW'(MAX_RETRY)) begin
          r_state <= ST_FAULT;
        end else begin
          r_state      <= ST_REPLAY;
          r_retryCnt   <= r_retryCnt + RW'(1);
          r_rdPtr      <= r_head;
          r_replayLeft <= r_count;
        end
      end else begin
        if (w_retire) begin
          r_retryCnt <= '0;
        end
        if (w_replayIssue) begin
          r_rdPtr      <= nextPtr(r_rdPtr);
          r_replayLeft <= r_replayLeft - CW'(1);
          if (r_replayLeft == CW'(1)) begin
            r_state <= ST_RUN;
          end
        end
      end
    end
  end

`ifdef ADDER_SCHED_ERR_CNT_EN
  logic [7:0] r_errCnt;

  // Counts every alarm event, including the one that enters FAULT.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_errCnt <= '0;
    end else if (w_error && (r_errCnt != 8'hFF)) begin
      r_errCnt <= r_errCnt + 8'd1;
    end
  end

  assign err_cnt = r_errCnt;
`else
  assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_adder_pipe_scheduler.sv
// -----------------------------------------------------------------------------
// tb_adder_pipe_scheduler
//
// Drives adder_pipe_scheduler with a one-layer chain whose sum is 2*x mod 16,
// injects parity alarms, and checks results through a scoreboard queue that
// a separate monitor drains whenever rsp_valid is seen.
// -----------------------------------------------------------------------------
module tb_adder_pipe_scheduler;

  localparam int W  = 4;
  localparam int L  = 1;
  localparam int MR = 3;

`ifdef ADDER_SCHED_ERR_CNT_EN
  localparam int ErrScale = 1;
`else
  localparam int ErrScale = 0;
`endif

  localparam int M_RUN    = 0;
  localparam int M_REPLAY = 1;
  localparam int M_FAULT  = 2;

  typedef struct {
    bit         id;
    logic [3:0] x;
  } item_t;

  typedef struct {
    bit         id;
    logic [3:0] r;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic [1:0]   req_valid;
  logic [7:0]   req_data;
  logic [1:0]   req_ready;
  logic [3:0]   pipe_in;
  logic [3:0]   pipe_out;
  logic [0:0]   pipe_alarm;
  logic         rsp_valid;
  logic         rsp_id;
  logic [3:0]   rsp_data;
  logic         fault;
  logic [7:0]   err_cnt;

  int nVectors = 0;
  int nMiss    = 0;

  // Reference model state
  int    mState;
  bit    mRr;
  int    mRetry;
  int    mErr;
  bit    mSlotV;
  int    mReplayIdx;
  item_t pend[$];
  exp_t  sbQ[$];

  adder_pipe_scheduler #(
    .WORD_WIDTH (W),
    .LAYERS     (L),
    .MAX_RETRY  (MR)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .pipe_in    (pipe_in),
    .pipe_out   (pipe_out),
    .pipe_alarm (pipe_alarm),
    .rsp_valid  (rsp_valid),
    .rsp_id     (rsp_id),
    .rsp_data   (rsp_data),
    .fault      (fault),
    .err_cnt    (err_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] chainResult(input logic [3:0] x);
    int v;
    v = int'(x) * 2;
    return 4'(v % 16);
  endfunction

  // Behavioural single-layer chain
  always @(posedge clk) begin
    pipe_out <= chainResult(pipe_in);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nVectors++;
    if (act !== exp) begin
      nMiss++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic modelReset();
    mState     = M_RUN;
    mRr        = 1'b0;
    mRetry     = 0;
    mErr       = 0;
    mSlotV     = 1'b0;
    mReplayIdx = 0;
    pend.delete();
    sbQ.delete();
  endtask

  // Predicts this cycle's outputs from the model, compares, then advances.
  task automatic checkOutput();
    bit         err;
    bit         ret;
    bit         iss;
    bit         g;
    bit         curFault;
    logic [1:0] expReady;
    logic [3:0] expPipe;
    item_t      it;
    exp_t       e;
    err      = mSlotV && (pipe_alarm[0] == 1'b1);
    ret      = mSlotV && !err;
    curFault = (mState == M_FAULT);
    expReady = 2'b00;
    expPipe  = 4'd0;
    iss      = 1'b0;
    if (ret) begin
      void'(pend.pop_front());
      if (mReplayIdx > 0) mReplayIdx--;
    end
    if (!err && mState == M_RUN && pend.size() < L && req_valid != 2'b00) begin
      g    = req_valid[mRr] ? mRr : !mRr;
      it.id = g;
      it.x  = g ? req_data[7:4] : req_data[3:0];
      pend.push_back(it);
      e.id = g;
      e.r  = chainResult(it.x);
      sbQ.push_back(e);
      expReady = g ? 2'b10 : 2'b01;
      expPipe  = it.x;
      iss      = 1'b1;
      mRr      = !g;
    end else if (!err && mState == M_REPLAY) begin
      it      = pend[mReplayIdx];
      expPipe = it.x;
      iss     = 1'b1;
      mReplayIdx++;
      if (mReplayIdx == pend.size()) mState = M_RUN;
    end

    check("req_ready", 32'(req_ready), 32'(expReady));
    check("pipe_in",   32'(pipe_in),   32'(expPipe));
    check("rsp_valid", 32'(rsp_valid), 32'(ret));
    check("fault",     32'(fault),     32'(curFault));
    check("err_cnt",   32'(err_cnt),   32'(mErr * ErrScale));

    if (err) begin
      if (mErr < 255) mErr++;
      if (mRetry == MR) begin
        mState = M_FAULT;
        pend.delete();
        sbQ.delete();
      end else begin
        mRetry++;
        mState     = M_REPLAY;
        mReplayIdx = 0;
      end
    end
    if (ret) mRetry = 0;
    mSlotV = iss;
  endtask

  task automatic applyStimulus(input logic [1:0] rv, input logic [3:0] x0,
                               input logic [3:0] x1, input logic al);
    @(posedge clk);
    #1;
    req_valid  = rv;
    req_data   = {x1, x0};
    pipe_alarm = al;
    #1;
    checkOutput();
  endtask

  task automatic doReset();
    @(posedge clk);
    #1;
    rst        = 1'b1;
    req_valid  = 2'b00;
    req_data   = 8'd0;
    pipe_alarm = 1'b0;
    sbQ.delete();
    @(posedge clk);
    #2;
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_id",    32'(rsp_id),    32'd0);
    check("rst_rsp_data",  32'(rsp_data),  32'd0);
    check("rst_pipe_in",   32'(pipe_in),   32'd0);
    check("rst_fault",     32'(fault),     32'd0);
    check("rst_err_cnt",   32'(err_cnt),   32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    modelReset();
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a result.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rsp_valid === 1'b1) begin
        if (sbQ.size() == 0) begin
          nVectors++;
          nMiss++;
          $display("[TB] FAIL unexpected_rsp: got id %0d data %0d, expected no response",
                   rsp_id, rsp_data);
        end else begin
          e = sbQ.pop_front();
          check("rsp_id",   32'(rsp_id),   32'(e.id));
          check("rsp_data", 32'(rsp_data), 32'(e.r));
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst        = 1'b1;
    req_valid  = 2'b00;
    req_data   = 8'd0;
    pipe_alarm = 1'b0;
    modelReset();
    doReset();

    // Requester 0 alone, back-to-back operands
    applyStimulus(2'b01, 4'd3, 4'd0, 1'b0);
    applyStimulus(2'b01, 4'd5, 4'd0, 1'b0);
    applyStimulus(2'b01, 4'd7, 4'd0, 1'b0);
    applyStimulus(2'b00, 4'd0, 4'd0, 1'b0);
    applyStimulus(2'b00, 4'd0, 4'd0, 1'b0);

    // Both requesters every cycle: grants alternate starting with 0
    doReset();
    repeat (4) applyStimulus(2'b11, 4'd1, 4'd2, 1'b0);
    applyStimulus(2'b00, 4'd0, 4'd0, 1'b0);

    // Single alarm on x=4 from requester 1: replay, original id kept
    doReset();
    applyStimulus(2'b10, 4'd0, 4'd4, 1'b0);
    applyStimulus(2'b00, 4'd0, 4'd0, 1'b1);
    applyStimulus(2'b00, 4'd0, 4'd0, 1'b0);
    applyStimulus(2'b00, 4'd0, 4'd0, 1'b0);
    check("replay_rsp_data", 32'(rsp_data), 32'd8);
    check("replay_rsp_id",   32'(rsp_id),   32'd1);
    check("replay_err_cnt",  32'(err_cnt),  32'(1 * ErrScale));

    // Alarm on every attempt: fault after the fourth
    doReset();
    applyStimulus(2'b01, 4'd9, 4'd0, 1'b0);
    repeat (10) applyStimulus(2'b00, 4'd0, 4'd0, 1'b1);
    repeat (3) applyStimulus(2'b11, 4'd1, 4'd2, 1'b0);
    check("fault_flag",      32'(fault),     32'd1);
    check("fault_req_ready", 32'(req_ready), 32'd0);
    check("fault_err_cnt",   32'(err_cnt),   32'(4 * ErrScale));

    // Reset in the middle of a replay
    doReset();
    applyStimulus(2'b01, 4'd5, 4'd0, 1'b0);
    applyStimulus(2'b00, 4'd0, 4'd0, 1'b1);
    doReset();
    applyStimulus(2'b01, 4'd1, 4'd0, 1'b0);
    applyStimulus(2'b00, 4'd0, 4'd0, 1'b0);
    check("post_reset_rsp_data", 32'(rsp_data), 32'd2);

    // Randomized traffic with sporadic alarms
    doReset();
    for (int i = 0; i < 600; i++) begin
      if ((i % 80) == 79 || mState == M_FAULT) begin
        doReset();
      end else begin
        applyStimulus(2'($urandom_range(0, 3)), 4'($urandom), 4'($urandom),
                      ($urandom_range(0, 5) == 0));
      end
    end

    repeat (4) applyStimulus(2'b00, 4'd0, 4'd0, 1'b0);
    check("drain_scoreboard", 32'(sbQ.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiss);
    $finish;
  end

endmodule
